// File: rtl/div47_seq_ctrl.sv
// ---------------------------------------------------------------------------
// div47_seq_ctrl
//
// Sequential divide-by-47 controller for a 60-bit unsigned dividend. One
// radix-64 digit (6 dividend bits) is retired per clock. The 6-bit running
// remainder chains from digit to digit, MSB digit first. Operand load, digit
// iteration and result hand-off run over valid/ready handshakes. This lets a
// single small digit stage be shared across cycles.
//
// Optional feature macro: DIV47_UNROLL2_EN
//   undefined : one digit stage per RUN cycle, 10 RUN cycles (latency 10)
//   defined   : two cascaded digit stages per RUN cycle, 5 RUN cycles
//               (latency 5)
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   in_valid   : dividend on in_x is valid
//   in_ready   : controller accepts a dividend this cycle
//   in_x       : 60-bit unsigned dividend
//   out_valid  : out_q/out_r hold a completed result
//   out_ready  : consumer takes the result this cycle
//   out_q      : floor(in_x / 47); bits 59:55 are always 0
//   out_r      : in_x mod 47, range 0..46
//   busy       : high while digits are being processed (RUN)
// ---------------------------------------------------------------------------
module div47_seq_ctrl #(
  parameter int W       = 60,
  parameter int DIVISOR = 47
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_x,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_q,
  output logic [5:0]   out_r,
  output logic         busy
);

`ifdef DIV47_UNROLL2_EN
  localparam int         STEP = 12;
  localparam logic [3:0] LAST = 4'd4;
`else
  localparam int         STEP = 6;
  localparam logic [3:0] LAST = 4'd9;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [W-1:0]      shift_r;
  logic [W-STEP-1:0] quo_r;     // only the low bits survive to the next cycle
  logic [5:0]        rem_r;
  logic [3:0]        cnt_r;

  logic [W-1:0]      shift_nxt;
  logic [W-1:0]      quo_nxt;
  logic [5:0]        rem_nxt;
  logic              accept;
  logic              last_digit;

  // One radix-64 digit step: v = {r, d} with r < 47, so v < 47*64 and the
  // quotient digit fits in 6 bits. Restoring compare/subtract tree over the
  // six shifted multiples of the divisor. Returns {qd, r_next}.
  function automatic logic [11:0] div47_step(input logic [11:0] v);
    logic [11:0] rem;
    logic [5:0]  qd;
    rem = v;
    qd  = '0;
    for (int k = 5; k >= 0; k--) begin
      if (rem >= (12'(DIVISOR) << k)) begin
        rem   = rem - (12'(DIVISOR) << k);
        qd[k] = 1'b1;
      end
    end
    return {qd, rem[5:0]};
  endfunction

  // Combinational digit datapath
`ifdef DIV47_UNROLL2_EN
  logic [11:0] step_a, step_b;
  always_comb begin
    step_a    = div47_step({rem_r, shift_r[W-1 -: 6]});
    // first stage's remainder feeds the second stage in the same cycle
    step_b    = div47_step({step_a[5:0], shift_r[W-7 -: 6]});
    quo_nxt   = {quo_r, step_a[11:6], step_b[11:6]};
    rem_nxt   = step_b[5:0];
    shift_nxt = shift_r << STEP;
  end
`else
  logic [11:0] step_a;
  always_comb begin
    step_a    = div47_step({rem_r, shift_r[W-1 -: 6]});
    quo_nxt   = {quo_r, step_a[11:6]};
    rem_nxt   = step_a[5:0];
    shift_nxt = shift_r << STEP;
  end
`endif

  assign accept     = in_valid && in_ready;
  assign last_digit = (state == RUN) && (cnt_r == LAST);

  // State register and control/result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt_r <= '0;
      rem_r <= '0;
      out_q <= '0;
      out_r <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt_r <= '0;
        rem_r <= '0;
      end else if (state == RUN) begin
        cnt_r <= cnt_r + 4'd1;
        rem_r <= rem_nxt;
        if (last_digit) begin
          out_q <= quo_nxt;
          out_r <= rem_nxt;
        end
      end
    end
  end

  // Operand shift register and quotient accumulator; every digit position
  // is overwritten during a run, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (accept) begin
      shift_r <= in_x;
    end else if (state == RUN) begin
      shift_r <= shift_nxt;
      quo_r   <= quo_nxt[W-STEP-1:0];
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = RUN;
      RUN:  if (cnt_r == LAST) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = in_valid ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    out_valid = (state == DONE);
    busy      = (state == RUN);
  end

endmodule

// File: doc/div47_seq_ctrl.md
# div47_seq_ctrl

Sequential controller that divides a 60-bit unsigned operand by the constant 47, one 6-bit radix-64 digit per clock. It chains the 6-bit remainder through ten digit steps and sequences operand load, digit iteration and result hand-off over valid/ready handshakes. It sits in front of the constant-division datapath and lets one small digit stage be shared across cycles instead of instantiating the full combinational 60-bit divider.

## Interface
- `W`, 60: dividend width; fixed multiple of 6; only 60 is supported.
- `DIVISOR`, 47: constant divisor; fixed; other values not supported.
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: dividend on `in_x` is valid.
- `in_ready` out 1: controller accepts a dividend this cycle.
- `in_x` in 60: unsigned dividend.
- `out_valid` out 1: `out_q`/`out_r` hold a completed result.
- `out_ready` in 1: consumer takes the result this cycle.
- `out_q` out 60: quotient `floor(in_x/47)`, zero-extended (bits 59:55 always 0).
- `out_r` out 6: remainder `in_x mod 47`, range 0..46.
- `busy` out 1: high in RUN.

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE, with `out_q`=0, `out_r`=0, `out_valid`=0, `busy`=0, `in_ready`=1, digit counter=0 and internal remainder=0.
- IDLE: `in_ready`=1. When `in_valid` is high, latch `in_x` into the shift register, clear the remainder and counter, and go to RUN.
- RUN: per cycle take digit d = shift[59:54], form v = {r,d} (12 bits; v < 47·64 because r < 47).
  - Quotient digit qd = floor(v/47), 6 bits. Next r = v − 47·qd.
  - Shift qd into the LSBs of the quotient register and shift the dividend left by 6.
  - Digits run MSB first. The counter counts 0..9. After digit 9, go to DONE.
- DONE: `out_valid`=1, and `out_q`/`out_r` are stable. On `out_ready`, leave DONE.
  - `in_ready` = IDLE | (DONE & `out_ready`).
  - If `out_ready` and `in_valid` are high together in DONE, accept the new operand and go directly to RUN. `out_valid` drops the next cycle.
  - If `out_ready` is high and `in_valid` is low, go to IDLE. `out_q`/`out_r` keep their last values.
- `in_valid` during RUN is ignored because `in_ready`=0. `in_x` is sampled only at the accepting edge.
- `out_ready` outside DONE has no effect.
- `rst` in any state, including mid-RUN, abandons the operation and restores the reset values on the next edge. No partial result appears.
- The digit step is pure combinational: a 12-bit compare/subtract tree or 12-input lookup. Its result must be bit-exact with integer division for all v < 3008.

## Timing
- Accept edge E0. Digits are processed on E1..E10. `out_valid` goes high after E10, giving 10 cycles of latency. With `DIV47_UNROLL2_EN` the latency is 5 cycles.
- Throughput: one result per 11 cycles with back-to-back DONE→RUN (6 with unroll).
- All outputs are registered. There are no combinational paths from `in_*` to `out_*`. `in_ready` depends combinationally on `out_ready` in DONE only.

## Configuration
- `DIV47_UNROLL2_EN` defined: two cascaded digit stages per RUN cycle. The first stage's remainder feeds the second stage in the same cycle. The counter runs 0..4, shifts are 12 bits per cycle, and latency is 5.
- `DIV47_UNROLL2_EN` undefined: one digit stage, counter 0..9, latency 10.
- Handshake, reset and results are identical in both builds.

## Test plan
- Reset, then `in_x`=47 → `out_valid` after 10 cycles (5 unrolled) with `out_q`=1 and `out_r`=0.
- `in_x`=0xFFF_FFFF_FFFF_FFFF (2^60−1) → `out_q`=24530244778869084 and `out_r`=27.
- `in_x`=46 with `out_ready` held low for 20 cycles → `out_valid` stays high, results stay stable (`out_q`=0, `out_r`=46), and `in_ready`=0 throughout.
- DONE with `out_ready`=1 and `in_valid`=1 (`in_x`=94) in the same cycle → the prior result is consumed, the next result is `out_q`=2 and `out_r`=0, and there is no IDLE cycle between.
- `rst` pulsed at RUN digit 4 → next cycle is IDLE with all outputs 0. A following `in_x`=1000 yields `out_q`=21 and `out_r`=13.
- 10k random `in_x` values with random `out_ready` stalls → every result matches the reference model `in_x/47` and `in_x%47`, and no result is dropped or duplicated.
